// File: rtl/battle_turn_sequencer.sv
// Battle turn sequencer: starts a battle on a new collision, alternates player and enemy
// strike pulses, latches both choices and ends the battle on an HP check.
module battle_turn_sequencer #(
    parameter int unsigned ENEMY_DELAY = 8,
    parameter logic [7:0]  LFSR_SEED   = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       collision_detected,
    input  logic       key_valid,
    input  logic [1:0] key_choice,
    input  logic [7:0] player_HP,
    input  logic [7:0] enemy_HP,
    input  logic [1:0] player_sword,
    input  logic [1:0] player_bat,
    input  logic [1:0] enemy_sword,
    input  logic [1:0] enemy_bat,
    output logic       battle_start,
    output logic       player_turn,
    output logic       attacker_turn,
    output logic [1:0] player_choice,
    output logic [1:0] enemy_choice,
    output logic       in_battle,
    output logic       battle_done,
    output logic       battle_won,
    output logic       key_reject,
    output logic [7:0] turn_count
);

    typedef enum logic [3:0] {
        IDLE, START, P_WAIT, P_HIT, P_CHK, E_WAIT, E_HIT, E_CHK, DONE
    } state_t;

    localparam logic [7:0] DELAY = 8'(ENEMY_DELAY);

    state_t     state, state_n;
    logic       coll_q;
    logic [7:0] lfsr;
    logic [7:0] cnt, cnt_n;
    logic [1:0] pchoice_n, echoice_n;
    logic [7:0] tcount_n;
    logic       won_n, reject_n;
    logic       new_coll, active, active_n, key_illegal, lfsr_fb;

    // Fall back to a weaker weapon when the enemy has run out of uses.
    function automatic logic [1:0] pick(input logic [1:0] r, input logic [1:0] es,
                                        input logic [1:0] eb);
        logic [1:0] c;
        c = r;
        if (r == 2'b11 && es == 2'd0) c = (eb != 2'd0) ? 2'b10 : 2'b01;
        else if (r == 2'b10 && eb == 2'd0) c = 2'b01;
        return c;
    endfunction

    always_comb begin
        new_coll    = collision_detected & ~coll_q;
        active      = (state != IDLE) && (state != DONE);
        key_illegal = (key_choice == 2'b10 && player_bat == 2'd0) ||
                      (key_choice == 2'b11 && player_sword == 2'd0);
        lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

        state_n   = state;
        cnt_n     = cnt;
        pchoice_n = player_choice;
        echoice_n = enemy_choice;
        reject_n  = 1'b0;

        case (state)
            IDLE:   if (new_coll) state_n = START;
            START:  state_n = P_WAIT;
            P_WAIT: if (key_valid) begin
                        if (key_illegal) begin
                            reject_n = 1'b1;
                        end else begin
                            pchoice_n = key_choice;
                            state_n   = P_HIT;
                        end
                    end
            P_HIT:  state_n = P_CHK;
            P_CHK:  if (enemy_HP == 8'd0) begin
                        state_n = DONE;
                    end else begin
                        cnt_n   = DELAY;
                        state_n = E_WAIT;
                    end
            E_WAIT: begin
                        cnt_n = cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            echoice_n = pick(lfsr[1:0], enemy_sword, enemy_bat);
                            state_n   = E_HIT;
                        end
                    end
            E_HIT:  state_n = E_CHK;
            E_CHK:  state_n = (player_HP == 8'd0) ? DONE : P_WAIT;
            DONE:   if (!collision_detected) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Losing the collision mid-battle wins over everything, including a same-cycle key.
        if (active && !collision_detected) begin
            state_n   = IDLE;
            cnt_n     = cnt;
            pchoice_n = player_choice;
            echoice_n = enemy_choice;
            reject_n  = 1'b0;
        end

        active_n = (state_n != IDLE) && (state_n != DONE);

        tcount_n = turn_count;
        if (state_n == START)
            tcount_n = 8'd0;
        else if (state == P_HIT && state_n == P_CHK && turn_count != 8'hFF)
            tcount_n = turn_count + 8'd1;

        won_n = 1'b0;
        if (state_n == DONE)
            won_n = (state == DONE) ? battle_won : (state == P_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            coll_q        <= 1'b1;
            lfsr          <= LFSR_SEED;
            cnt           <= 8'd0;
            battle_start  <= 1'b0;
            player_turn   <= 1'b0;
            attacker_turn <= 1'b0;
            player_choice <= 2'b00;
            enemy_choice  <= 2'b00;
            in_battle     <= 1'b0;
            battle_done   <= 1'b0;
            battle_won    <= 1'b0;
            key_reject    <= 1'b0;
            turn_count    <= 8'd0;
        end else begin
            state         <= state_n;
            coll_q        <= collision_detected;
            lfsr          <= {lfsr[6:0], lfsr_fb};
            cnt           <= cnt_n;
            battle_start  <= (state_n == START);
            player_turn   <= (state_n == P_HIT);
            attacker_turn <= (state_n == E_HIT);
            player_choice <= pchoice_n;
            enemy_choice  <= echoice_n;
            in_battle     <= active_n;
            battle_done   <= (state_n == DONE);
            battle_won    <= won_n;
            key_reject    <= reject_n;
            turn_count    <= tcount_n;
        end
    end

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Directed bench for battle_turn_sequencer with ENEMY_DELAY=8.
module tb_battle_turn_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       collision_detected, key_valid;
    logic [1:0] key_choice, player_sword, player_bat, enemy_sword, enemy_bat;
    logic [7:0] player_HP, enemy_HP;
    logic       battle_start, player_turn, attacker_turn, in_battle;
    logic       battle_done, battle_won, key_reject;
    logic [1:0] player_choice, enemy_choice;
    logic [7:0] turn_count;

    int checks = 0;
    int errors = 0;

    battle_turn_sequencer #(.ENEMY_DELAY(8), .LFSR_SEED(8'h5A)) dut (
        .clk(clk), .rst(rst),
        .collision_detected(collision_detected),
        .key_valid(key_valid), .key_choice(key_choice),
        .player_HP(player_HP), .enemy_HP(enemy_HP),
        .player_sword(player_sword), .player_bat(player_bat),
        .enemy_sword(enemy_sword), .enemy_bat(enemy_bat),
        .battle_start(battle_start), .player_turn(player_turn),
        .attacker_turn(attacker_turn), .player_choice(player_choice),
        .enemy_choice(enemy_choice), .in_battle(in_battle),
        .battle_done(battle_done), .battle_won(battle_won),
        .key_reject(key_reject), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] k);
        key_valid  = 1'b1;
        key_choice = k;
        tick();
        key_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; collision_detected = 1'b0; key_valid = 1'b0; key_choice = 2'b00;
        player_HP = 8'd100; enemy_HP = 8'd100;
        player_sword = 2'd3; player_bat = 2'd3; enemy_sword = 2'd3; enemy_bat = 2'd3;
        repeat (3) tick();
        checks++; if (battle_start !== 1'b0) begin errors++; $display("FAIL rst_start got %0b exp 0", battle_start); end
        checks++; if (in_battle !== 1'b0) begin errors++; $display("FAIL rst_in_battle got %0b exp 0", in_battle); end
        checks++; if (battle_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", battle_done); end
        checks++; if (turn_count !== 8'd0) begin errors++; $display("FAIL rst_turn_count got %0d exp 0", turn_count); end
        checks++; if ({player_choice, enemy_choice} !== 4'b0) begin errors++; $display("FAIL rst_choices got %b exp 0000", {player_choice, enemy_choice}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start();
        collision_detected = 1'b1;
        tick();
        checks++; if (battle_start !== 1'b1) begin errors++; $display("FAIL t1_start got %0b exp 1", battle_start); end
        checks++; if (in_battle !== 1'b1) begin errors++; $display("FAIL t1_in_battle got %0b exp 1", in_battle); end
        tick();
        checks++; if (battle_start !== 1'b0) begin errors++; $display("FAIL t1_start_pulse got %0b exp 0", battle_start); end
        checks++; if (in_battle !== 1'b1) begin errors++; $display("FAIL t1_in_battle_hold got %0b exp 1", in_battle); end
    endtask

    task automatic test_player_strike();
        logic [2:0] exp_p;
        player_sword = 2'd0;
        press(2'b01);
        checks++; if ({player_turn, attacker_turn} !== 2'b10) begin errors++; $display("FAIL t2_player_turn got %b exp 10", {player_turn, attacker_turn}); end
        checks++; if (player_choice !== 2'b01) begin errors++; $display("FAIL t2_player_choice got %b exp 01", player_choice); end
        for (int i = 1; i <= 11; i++) begin
            // A rejectable key during the enemy's wait must be ignored entirely.
            if (i == 4) begin key_valid = 1'b1; key_choice = 2'b11; end
            tick();
            key_valid = 1'b0;
            exp_p = {(i == 10), 1'b0, 1'b0};
            checks++;
            if ({attacker_turn, player_turn, key_reject} !== exp_p) begin
                errors++;
                $display("FAIL t2_enemy_timing cyc %0d got %b exp %b", i, {attacker_turn, player_turn, key_reject}, exp_p);
            end
        end
        checks++; if (turn_count !== 8'd1) begin errors++; $display("FAIL t2_turn_count got %0d exp 1", turn_count); end
        checks++; if (player_choice !== 2'b01) begin errors++; $display("FAIL t2_choice_hold got %b exp 01", player_choice); end
        tick();
    endtask

    task automatic test_reject();
        press(2'b11);
        checks++; if ({key_reject, player_turn} !== 2'b10) begin errors++; $display("FAIL t3_reject got %b exp 10", {key_reject, player_turn}); end
        tick();
        checks++; if ({key_reject, player_turn, in_battle} !== 3'b001) begin errors++; $display("FAIL t3_after_reject got %b exp 001", {key_reject, player_turn, in_battle}); end
        press(2'b00);
        checks++; if ({player_turn, key_reject} !== 2'b10) begin errors++; $display("FAIL t3_punch_turn got %b exp 10", {player_turn, key_reject}); end
        checks++; if (player_choice !== 2'b00) begin errors++; $display("FAIL t3_punch_choice got %b exp 00", player_choice); end
    endtask

    task automatic test_enemy_dead();
        enemy_HP = 8'd0;
        tick();
        checks++; if (turn_count !== 8'd2) begin errors++; $display("FAIL t4_turn_count got %0d exp 2", turn_count); end
        tick();
        checks++; if ({battle_done, battle_won, in_battle} !== 3'b110) begin errors++; $display("FAIL t4_won got %b exp 110", {battle_done, battle_won, in_battle}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({battle_done, battle_won, attacker_turn} !== 3'b110) begin errors++; $display("FAIL t4_done_hold cyc %0d got %b exp 110", i, {battle_done, battle_won, attacker_turn}); end
        end
        collision_detected = 1'b0;
        tick();
        checks++; if ({battle_done, battle_won} !== 2'b00) begin errors++; $display("FAIL t4_idle got %b exp 00", {battle_done, battle_won}); end
        enemy_HP = 8'd100;
    endtask

    task automatic test_player_dead();
        logic seen;
        int   bad_choice;
        enemy_sword = 2'd0; enemy_bat = 2'd0;
        bad_choice = 0;
        collision_detected = 1'b1;
        tick();
        checks++; if ({battle_start, turn_count} !== {1'b1, 8'd0}) begin errors++; $display("FAIL t5_start got %b/%0d exp 1/0", battle_start, turn_count); end
        tick();
        for (int r = 0; r < 256; r++) begin
            press(2'b01);
            seen = 1'b0;
            for (int w = 0; w < 20 && !seen; w++) begin
                tick();
                if (attacker_turn) seen = 1'b1;
            end
            checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t5_enemy_turn round %0d got 0 exp 1", r); end
            if (enemy_choice[1] !== 1'b0) bad_choice++;
            if (r == 255) player_HP = 8'd0;
            tick();
            tick();
        end
        checks++; if (bad_choice !== 0) begin errors++; $display("FAIL t5_enemy_choice_legal got %0d illegal exp 0", bad_choice); end
        checks++; if ({battle_done, battle_won, in_battle} !== 3'b100) begin errors++; $display("FAIL t5_lost got %b exp 100", {battle_done, battle_won, in_battle}); end
        checks++; if (turn_count !== 8'd255) begin errors++; $display("FAIL t5_turn_sat got %0d exp 255", turn_count); end
        collision_detected = 1'b0;
        tick();
        player_HP = 8'd100;
    endtask

    task automatic test_abort();
        logic seen;
        collision_detected = 1'b1;
        tick();
        tick();
        press(2'b01);
        tick();
        tick();
        collision_detected = 1'b0;
        tick();
        checks++; if ({in_battle, battle_done} !== 2'b00) begin errors++; $display("FAIL t6_abort got %b exp 00", {in_battle, battle_done}); end
        seen = 1'b0;
        repeat (12) begin tick(); if (attacker_turn || battle_done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t6_no_attack got %0b exp 0", seen); end

        collision_detected = 1'b1;
        tick();
        checks++; if (battle_start !== 1'b1) begin errors++; $display("FAIL t6_restart got %0b exp 1", battle_start); end
        rst = 1'b1;
        tick();
        checks++; if ({in_battle, battle_start} !== 2'b00) begin errors++; $display("FAIL t6_rst_mid got %b exp 00", {in_battle, battle_start}); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin tick(); if (battle_start || in_battle) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t6_no_start_after_rst got %0b exp 0", seen); end
        collision_detected = 1'b0;
        tick();
        collision_detected = 1'b1;
        tick();
        checks++; if (battle_start !== 1'b1) begin errors++; $display("FAIL t6_toggle_start got %0b exp 1", battle_start); end
        tick();
        key_valid = 1'b1; key_choice = 2'b01; collision_detected = 1'b0;
        tick();
        key_valid = 1'b0;
        checks++; if ({player_turn, key_reject, in_battle} !== 3'b000) begin errors++; $display("FAIL t6_key_on_abort got %b exp 000", {player_turn, key_reject, in_battle}); end
        tick();
        checks++; if (player_turn !== 1'b0) begin errors++; $display("FAIL t6_key_on_abort_late got %0b exp 0", player_turn); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_player_strike();
        test_reject();
        test_enemy_dead();
        test_player_dead();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
